// File: rtl/cart_bank_mapper.sv
// MSX megaROM bank mapper (ASCII8, ASCII16, Konami, Konami SCC): CPU address + bank registers -> linear ROM byte address.
// Optional battery SRAM mapping in the ASCII modes is enabled with `define CART_MAPPER_SRAM_EN.
module cart_bank_mapper #(
  parameter int ADDR_W   = 25,
  parameter int BANK_W   = 8,
  parameter int SRAM_BIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] rom_size,
  input  logic [15:0]       addr,
  input  logic [7:0]        d_from_cpu,
  input  logic              wr,
  input  logic              cs,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              sram_cs,
  output logic              sram_we
);

  typedef enum logic [1:0] {
    MODE_ASCII8     = 2'd0,
    MODE_ASCII16    = 2'd1,
    MODE_KONAMI     = 2'd2,
    MODE_KONAMI_SCC = 2'd3
  } mode_t;

  localparam int WIDE_W = (ADDR_W > BANK_W + 14) ? ADDR_W : BANK_W + 14;

  mode_t             mode_q;
  logic [BANK_W-1:0] bank_q [4];

  logic              wr_hit;
  logic [1:0]        wr_sel;

  logic [1:0]        p8;
  logic              p16;
  logic              ascii16;
  logic [BANK_W-1:0] sel_bank;
  logic [BANK_W-1:0] bank_eff;
  logic [BANK_W-1:0] mask8;
  logic [BANK_W-1:0] mask16;
  logic [ADDR_W-1:0] size_sh8;
  logic [ADDR_W-1:0] size_sh16;
  logic [WIDE_W-1:0] wide_addr;

  // Mode is latched only while reset is held; it never changes at run time.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= mode_t'(mode);
    end
  end

  // Bank register write decode, per latched mode.
  always_comb begin
    wr_hit = 1'b0;
    wr_sel = 2'd0;
    unique case (mode_q)
      MODE_ASCII8: begin
        wr_hit = (addr[15:13] == 3'b011);
        wr_sel = addr[12:11];
      end
      MODE_ASCII16: begin
        wr_hit = (addr[15:13] == 3'b011) && !addr[11];
        wr_sel = {1'b0, addr[12]};
      end
      MODE_KONAMI: begin
        wr_hit = (addr[15:13] inside {3'd3, 3'd4, 3'd5});
        wr_sel = addr[14:13] + 2'd2;
      end
      MODE_KONAMI_SCC: begin
        wr_hit = (addr[12:11] == 2'b10) && (addr[15:13] inside {3'd2, 3'd3, 3'd4, 3'd5});
        wr_sel = addr[14:13] + 2'd2;
      end
      default: begin
        wr_hit = 1'b0;
        wr_sel = 2'd0;
      end
    endcase
  end

  // Konami modes boot with banks 0..3 so the fixed first page holds the entry point.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        bank_q[i] <= mode[1] ? BANK_W'(i) : '0;
      end else if (cs && wr && wr_hit && (wr_sel == 2'(i))) begin
        bank_q[i] <= d_from_cpu[BANK_W-1:0];
      end
    end
  end

  assign p8        = {~addr[14], addr[13]};
  assign p16       = ~addr[14];
  assign ascii16   = (mode_q == MODE_ASCII16);
  assign size_sh8  = rom_size >> 13;
  assign size_sh16 = rom_size >> 14;
  assign mask8     = (size_sh8  == '0) ? '0 : BANK_W'(size_sh8  - ADDR_W'(1));
  assign mask16    = (size_sh16 == '0) ? '0 : BANK_W'(size_sh16 - ADDR_W'(1));

  always_comb begin
    wide_addr = '0;
    sel_bank  = ascii16 ? bank_q[{1'b0, p16}] : bank_q[p8];
    bank_eff  = sel_bank & (ascii16 ? mask16 : mask8);
`ifdef CART_MAPPER_SRAM_EN
    if (!mode_q[1]) begin
      bank_eff[SRAM_BIT] = 1'b0;
    end
`endif
    if (ascii16) begin
      wide_addr[BANK_W+13:0] = {bank_eff, addr[13:0]};
    end else begin
      wide_addr[BANK_W+12:0] = {bank_eff, addr[12:0]};
    end
    mem_addr = wide_addr[ADDR_W-1:0];
  end

`ifdef CART_MAPPER_SRAM_EN
  // SRAM is read-only through 4000-7FFF; only the 8000-BFFF window can write it.
  assign sram_cs = !mode_q[1] && cs && sel_bank[SRAM_BIT];
  assign sram_we = sram_cs && wr && (addr[15:14] == 2'b10);
`else
  assign sram_cs = 1'b0;
  assign sram_we = 1'b0;
`endif

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed self-checking bench for cart_bank_mapper; SRAM expectations follow CART_MAPPER_SRAM_EN.
`timescale 1ns/1ps
module tb_cart_bank_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [24:0] rom_size = 25'h0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  d_from_cpu = 8'h0;
  logic        wr = 1'b0;
  logic        cs = 1'b0;
  logic [24:0] mem_addr;
  logic        sram_cs;
  logic        sram_we;

  int checks = 0;
  int errors = 0;

  cart_bank_mapper #(.ADDR_W(25), .BANK_W(8), .SRAM_BIT(7)) dut (
    .clk(clk), .reset(reset), .mode(mode), .rom_size(rom_size), .addr(addr),
    .d_from_cpu(d_from_cpu), .wr(wr), .cs(cs), .mem_addr(mem_addr),
    .sram_cs(sram_cs), .sram_we(sram_we)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic [1:0] m, input logic [24:0] rs);
    @(negedge clk);
    reset = 1'b1; mode = m; rom_size = rs; wr = 1'b0; cs = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset mode=%0d rom_size=%h", m, rs);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic sel);
    @(negedge clk);
    addr = a; d_from_cpu = d; cs = sel; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; cs = 1'b1;
    $display("write cs=%0b addr=%h data=%h", sel, a, d);
  endtask

  task automatic drive_read(input logic [15:0] a);
    @(negedge clk);
    addr = a; wr = 1'b0; cs = 1'b1;
    #1;
    $display("read addr=%h mem_addr=%h sram_cs=%0b", a, mem_addr, sram_cs);
  endtask

  task automatic test_reset;
    logic [15:0] ra [4];
    ra = '{16'h4000, 16'h6000, 16'h8000, 16'hA000};
    do_reset(2'd0, 25'h40000);
    for (int i = 0; i < 4; i++) begin
      drive_read(ra[i]);
      checks++;
      if (mem_addr !== 25'h0) begin
        errors++;
        $display("FAIL reset_read addr=%h got %h expected %h", ra[i], mem_addr, 25'h0);
      end
    end
    checks++;
    if (sram_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_sram_cs got %b expected 0", sram_cs);
    end
  endtask

  task automatic test_ascii8;
    cpu_write(16'h6800, 8'h05, 1'b1);
    drive_read(16'h6123);
    checks++;
    if (mem_addr !== 25'h0A123) begin
      errors++; $display("FAIL a8_bank1 got %h expected %h", mem_addr, 25'h0A123);
    end
    cpu_write(16'h6000, 8'h07, 1'b0);
    drive_read(16'h4000);
    checks++;
    if (mem_addr !== 25'h00000) begin
      errors++; $display("FAIL a8_cs_gate got %h expected %h", mem_addr, 25'h0);
    end
    cpu_write(16'h7800, 8'h02, 1'b1);
    drive_read(16'hBFFF);
    checks++;
    if (mem_addr !== 25'h05FFF) begin
      errors++; $display("FAIL a8_bank3 got %h expected %h", mem_addr, 25'h05FFF);
    end
    drive_read(16'h2123);
    checks++;
    if (mem_addr !== 25'h04123) begin
      errors++; $display("FAIL a8_mirror_low got %h expected %h", mem_addr, 25'h04123);
    end
    drive_read(16'hC123);
    checks++;
    if (mem_addr !== 25'h00123) begin
      errors++; $display("FAIL a8_mirror_high got %h expected %h", mem_addr, 25'h00123);
    end
  endtask

  task automatic test_konami;
    do_reset(2'd2, 25'h20000);
    drive_read(16'hA010);
    checks++;
    if (mem_addr !== 25'h06010) begin
      errors++; $display("FAIL kon_reset_bank3 got %h expected %h", mem_addr, 25'h06010);
    end
    drive_read(16'h6000);
    checks++;
    if (mem_addr !== 25'h02000) begin
      errors++; $display("FAIL kon_reset_bank1 got %h expected %h", mem_addr, 25'h02000);
    end
    cpu_write(16'h8000, 8'h1F, 1'b1);
    drive_read(16'h8000);
    checks++;
    if (mem_addr !== 25'h1E000) begin
      errors++; $display("FAIL kon_mask got %h expected %h", mem_addr, 25'h1E000);
    end
    cpu_write(16'h4000, 8'h05, 1'b1);
    cpu_write(16'h5000, 8'h07, 1'b1);
    drive_read(16'h4000);
    checks++;
    if (mem_addr !== 25'h00000) begin
      errors++; $display("FAIL kon_bank0_fixed got %h expected %h", mem_addr, 25'h0);
    end
    cpu_write(16'h6000, 8'h13, 1'b1);
    drive_read(16'h7FFF);
    checks++;
    if (mem_addr !== 25'h07FFF) begin
      errors++; $display("FAIL kon_bank1_write got %h expected %h", mem_addr, 25'h07FFF);
    end
  endtask

  task automatic test_konami_scc;
    do_reset(2'd3, 25'h20000);
    drive_read(16'h8000);
    checks++;
    if (mem_addr !== 25'h04000) begin
      errors++; $display("FAIL scc_reset_bank2 got %h expected %h", mem_addr, 25'h04000);
    end
    cpu_write(16'h5000, 8'h07, 1'b1);
    cpu_write(16'h5800, 8'h09, 1'b1);
    drive_read(16'h4000);
    checks++;
    if (mem_addr !== 25'h0E000) begin
      errors++; $display("FAIL scc_bank0 got %h expected %h", mem_addr, 25'h0E000);
    end
    cpu_write(16'hB000, 8'h04, 1'b1);
    cpu_write(16'hA000, 8'h06, 1'b1);
    drive_read(16'hA001);
    checks++;
    if (mem_addr !== 25'h08001) begin
      errors++; $display("FAIL scc_bank3 got %h expected %h", mem_addr, 25'h08001);
    end
  endtask

  task automatic test_ascii16;
    do_reset(2'd1, 25'h80000);
    cpu_write(16'h7000, 8'h03, 1'b1);
    drive_read(16'h8004);
    checks++;
    if (mem_addr !== 25'h0C004) begin
      errors++; $display("FAIL a16_bank1 got %h expected %h", mem_addr, 25'h0C004);
    end
    cpu_write(16'h7800, 8'h05, 1'b1);
    drive_read(16'h8004);
    checks++;
    if (mem_addr !== 25'h0C004) begin
      errors++; $display("FAIL a16_ignore_7800 got %h expected %h", mem_addr, 25'h0C004);
    end
    mode = 2'd2;
    cpu_write(16'h6000, 8'h02, 1'b1);
    drive_read(16'h4000);
    checks++;
    if (mem_addr !== 25'h08000) begin
      errors++; $display("FAIL a16_mode_hold_bank0 got %h expected %h", mem_addr, 25'h08000);
    end
    drive_read(16'h8004);
    checks++;
    if (mem_addr !== 25'h0C004) begin
      errors++; $display("FAIL a16_mode_hold_bank1 got %h expected %h", mem_addr, 25'h0C004);
    end
    cpu_write(16'h7000, 8'h25, 1'b1);
    drive_read(16'h0004);
    checks++;
    if (mem_addr !== 25'h14004) begin
      errors++; $display("FAIL a16_mask_mirror got %h expected %h", mem_addr, 25'h14004);
    end
  endtask

  task automatic test_mask_zero;
    do_reset(2'd0, 25'h01000);
    cpu_write(16'h6000, 8'hFF, 1'b1);
    drive_read(16'h4ABC);
    checks++;
    if (mem_addr !== 25'h00ABC) begin
      errors++; $display("FAIL mask_zero got %h expected %h", mem_addr, 25'h00ABC);
    end
  endtask

  task automatic test_reset_priority;
    do_reset(2'd0, 25'h40000);
    cpu_write(16'h6000, 8'h01, 1'b1);
    drive_read(16'h4000);
    checks++;
    if (mem_addr !== 25'h02000) begin
      errors++; $display("FAIL prio_pre got %h expected %h", mem_addr, 25'h02000);
    end
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; wr = 1'b1; addr = 16'h6000; d_from_cpu = 8'h12;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0;
    $display("reset+write addr=6000 data=12");
    drive_read(16'h4000);
    checks++;
    if (mem_addr !== 25'h00000) begin
      errors++; $display("FAIL prio_reset_wins got %h expected %h", mem_addr, 25'h0);
    end
  endtask

  task automatic test_sram;
    logic        exp_cs_hi;
    logic        exp_we_hi;
    logic [24:0] exp_addr;
`ifdef CART_MAPPER_SRAM_EN
    exp_cs_hi = 1'b1; exp_we_hi = 1'b1; exp_addr = 25'h000000;
`else
    exp_cs_hi = 1'b0; exp_we_hi = 1'b0; exp_addr = 25'h100000;
`endif
    do_reset(2'd0, 25'h200000);
    cpu_write(16'h7000, 8'h80, 1'b1);
    @(negedge clk);
    addr = 16'h8000; d_from_cpu = 8'h55; cs = 1'b1; wr = 1'b1;
    #1;
    $display("sram write addr=8000 sram_cs=%0b sram_we=%0b mem_addr=%h", sram_cs, sram_we, mem_addr);
    checks++;
    if (sram_cs !== exp_cs_hi) begin
      errors++; $display("FAIL sram_cs_8000 got %b expected %b", sram_cs, exp_cs_hi);
    end
    checks++;
    if (sram_we !== exp_we_hi) begin
      errors++; $display("FAIL sram_we_8000 got %b expected %b", sram_we, exp_we_hi);
    end
    checks++;
    if (mem_addr !== exp_addr) begin
      errors++; $display("FAIL sram_addr_8000 got %h expected %h", mem_addr, exp_addr);
    end
    @(posedge clk); #1;
    wr = 1'b0;
    cpu_write(16'h6000, 8'h80, 1'b1);
    @(negedge clk);
    addr = 16'h4000; d_from_cpu = 8'hAA; cs = 1'b1; wr = 1'b1;
    #1;
    $display("sram write addr=4000 sram_cs=%0b sram_we=%0b mem_addr=%h", sram_cs, sram_we, mem_addr);
    checks++;
    if (sram_cs !== exp_cs_hi) begin
      errors++; $display("FAIL sram_cs_4000 got %b expected %b", sram_cs, exp_cs_hi);
    end
    checks++;
    if (sram_we !== 1'b0) begin
      errors++; $display("FAIL sram_we_4000 got %b expected 0", sram_we);
    end
    checks++;
    if (mem_addr !== exp_addr) begin
      errors++; $display("FAIL sram_addr_4000 got %h expected %h", mem_addr, exp_addr);
    end
    @(posedge clk); #1;
    wr = 1'b0; cs = 1'b0;
    #1;
    checks++;
    if (sram_cs !== 1'b0) begin
      errors++; $display("FAIL sram_cs_deselected got %b expected 0", sram_cs);
    end
    cs = 1'b1;
    do_reset(2'd2, 25'h200000);
    cpu_write(16'h8000, 8'h80, 1'b1);
    drive_read(16'h8000);
    checks++;
    if (sram_cs !== 1'b0) begin
      errors++; $display("FAIL sram_cs_konami got %b expected 0", sram_cs);
    end
  endtask

  initial begin
    test_reset();
    test_ascii8();
    test_konami();
    test_konami_scc();
    test_ascii16();
    test_mask_zero();
    test_reset_priority();
    test_sram();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
